// File: rtl/bsc_ompss_tstamp_pkg.sv
// Shared types and constants for the OmpSs timestamp reader: FSM states, counter word offsets, AXI response codes.
package bsc_ompss_tstamp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR_LO,
    R_LO,
    AR_HI,
    R_HI,
    OUT
  } state_t;

  localparam logic [31:0] LO_OFFSET = 32'd0;
  localparam logic [31:0] HI_OFFSET = 32'd4;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/bsc_ompss_tstamp_period.sv
// Auto-sample ticker: raises pending every C_PERIOD cycles and holds it until a sequence starts.
// Latency: pending one cycle after the counter reaches zero; no backpressure, extra ticks while pending are dropped.
module bsc_ompss_tstamp_period #(
  parameter int C_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic pending
);

  localparam logic [15:0] RELOAD = 16'(C_PERIOD - 1);

  logic [15:0] cnt_q;
  logic        tick;

  assign tick = (cnt_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= RELOAD;
      pending <= 1'b0;
    end else begin
      cnt_q <= tick ? RELOAD : cnt_q - 16'd1;
      // A start consumes the request even if a tick lands on the same cycle.
      if (start)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/bsc_ompss_tstamp_reader.sv
// AXI4-Lite reader assembling a coherent 64-bit timestamp {hi, lo} (low word first); BSC_OMPSS_TSTAMP_PERIODIC_EN adds auto-sampling.
// Latency: tstamp_valid 7 cycles after request against a zero-wait slave; stalls in OUT while tstamp_ready is low.
module bsc_ompss_tstamp_reader
  import bsc_ompss_tstamp_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 3,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_COUNTER_BASE     = 32'h0,
  parameter int          C_PERIOD           = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  input  logic                            req_valid,
  output logic                            req_ready,
  output logic [2*C_M_AXI_DATA_WIDTH-1:0] tstamp_data,
  output logic                            tstamp_err,
  output logic                            tstamp_valid,
  input  logic                            tstamp_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LO_ADDR = C_M_AXI_ADDR_WIDTH'(C_COUNTER_BASE + LO_OFFSET);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] HI_ADDR = C_M_AXI_ADDR_WIDTH'(C_COUNTER_BASE + HI_OFFSET);

  state_t                          state, state_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0]   lo_q, hi_q;
  logic                            err_q;
  logic                            pending;
  logic                            start;

  // Held low during reset so nothing is accepted before the slave is also out of reset.
  assign req_ready = (state == IDLE) && !m_axi_areset;
  assign start     = req_ready && (req_valid || pending);

`ifdef BSC_OMPSS_TSTAMP_PERIODIC_EN
  bsc_ompss_tstamp_period #(
    .C_PERIOD (C_PERIOD)
  ) u_period (
    .clk     (m_axi_aclk),
    .rst     (m_axi_areset),
    .start   (start),
    .pending (pending)
  );
`else
  logic unused_period;
  assign unused_period = |C_PERIOD;
  assign pending       = 1'b0;
`endif

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_rready  = 1'b0;
    tstamp_valid  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = AR_LO;
      AR_LO: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = LO_ADDR;
        if (m_axi_arready) state_nxt = R_LO;
      end
      R_LO: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = AR_HI;
      end
      AR_HI: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = HI_ADDR;
        if (m_axi_arready) state_nxt = R_HI;
      end
      R_HI: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = OUT;
      end
      OUT: begin
        tstamp_valid = 1'b1;
        if (tstamp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An error response only marks the result; both beats always complete.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      lo_q  <= '0;
      hi_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == R_LO && m_axi_rvalid) begin
        lo_q  <= m_axi_rdata;
        err_q <= err_q | (m_axi_rresp != RESP_OKAY);
      end
      if (state == R_HI && m_axi_rvalid) begin
        hi_q  <= m_axi_rdata;
        err_q <= err_q | (m_axi_rresp != RESP_OKAY);
      end
      if (state == OUT && tstamp_ready)
        err_q <= 1'b0;
    end
  end

  assign tstamp_data = {hi_q, lo_q};
  assign tstamp_err  = err_q;

endmodule

// File: tb/tb_bsc_ompss_tstamp_reader.sv
// Bench for bsc_ompss_tstamp_reader: behavioural hardware-counter slave, directed vector table, random traffic.
module tb_bsc_ompss_tstamp_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] tstamp_data;
  logic        tstamp_err;
  logic        tstamp_valid;
  logic        tstamp_ready = 1'b1;
  logic [2:0]  araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  bsc_ompss_tstamp_reader #(
    .C_M_AXI_ADDR_WIDTH (3),
    .C_M_AXI_DATA_WIDTH (32),
    .C_COUNTER_BASE     (32'h0),
    .C_PERIOD           (16)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_areset  (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .tstamp_data   (tstamp_data),
    .tstamp_err    (tstamp_err),
    .tstamp_valid  (tstamp_valid),
    .tstamp_ready  (tstamp_ready),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  // Hardware counter slave: free-running 64-bit counter, low read latches the upper half.
  logic [63:0] cnt = '0;
  logic [63:0] force_val = '0;
  bit          force_req = 0;
  int          ar_dly = 0, r_dly = 0;
  bit          inj_err_lo = 0, inj_err_hi = 0;
  int          a_cnt = 0, r_wait = 0;
  bit          r_busy = 0, beat_hi = 0, lo_err = 0;
  logic [31:0] hi_latch = '0, lo_seen = '0;
  logic [63:0] last_exp_data = '0;
  bit          last_exp_err = 0;

  always @(posedge clk) begin
    cnt <= force_req ? force_val : cnt + 64'd1;
    if (rst) begin
      arready <= 1'b0; rvalid <= 1'b0; r_busy <= 0; a_cnt <= 0; r_wait <= 0;
    end else begin
      if (arvalid && arready) begin
        arready <= 1'b0;
        r_busy  <= 1;
        beat_hi <= (araddr == 3'd4);
        if (araddr == 3'd4) begin
          rdata <= hi_latch;
          rresp <= inj_err_hi ? 2'b10 : 2'b00;
        end else begin
          rdata    <= cnt[31:0];
          hi_latch <= cnt[63:32];
          rresp    <= inj_err_lo ? 2'b10 : 2'b00;
        end
        r_wait <= r_dly;
        rvalid <= (r_dly == 0);
      end else if (arvalid && !arready && !r_busy) begin
        if (a_cnt >= ar_dly) begin arready <= 1'b1; a_cnt <= 0; end
        else a_cnt <= a_cnt + 1;
      end
      if (r_busy && !rvalid && r_wait > 0) begin
        r_wait <= r_wait - 1;
        if (r_wait == 1) rvalid <= 1'b1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        r_busy <= 0;
        if (beat_hi) begin
          last_exp_data <= {rdata, lo_seen};
          last_exp_err  <= lo_err || (rresp != 2'b00);
        end else begin
          lo_seen <= rdata;
          lo_err  <= (rresp != 2'b00);
        end
      end
    end
  end

  // Protocol monitor: AR stability, one outstanding read, lo/hi order, output hold under backpressure.
  int          prot_viol = 0;
  bit          prev_arv = 0, prev_hs = 0, expect_hi = 0, prev_tv = 0, prev_tr = 0;
  logic [2:0]  prev_addr = '0;
  logic [63:0] prev_td = '0;

  always @(posedge clk) begin
    if (rst) begin
      prev_arv <= 0; prev_hs <= 0; expect_hi <= 0; prev_tv <= 0;
    end else begin
      if (prev_arv && !prev_hs && (!arvalid || araddr != prev_addr)) prot_viol++;
      if (arvalid && (rvalid || r_busy)) prot_viol++;
      if (arvalid && arready) begin
        if (araddr != (expect_hi ? 3'd4 : 3'd0)) prot_viol++;
        expect_hi <= !expect_hi;
      end
      if (prev_tv && !prev_tr && (!tstamp_valid || tstamp_data != prev_td)) prot_viol++;
      prev_arv  <= arvalid;
      prev_hs   <= arvalid && arready;
      prev_addr <= araddr;
      prev_tv   <= tstamp_valid;
      prev_tr   <= tstamp_ready;
      prev_td   <= tstamp_data;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after the request edge; returns the 1-based cycle at which tstamp_valid is seen.
  task automatic wait_valid(input bit drop_req, output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (drop_req && k == 1) req_valid = 1'b0;
      if (tstamp_valid) begin
        cyc = k;
        ok  = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [63:0] force_val;
    int          idle_wait;
    bit          err_lo;
    bit          err_hi;
    logic [63:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit ok;
    @(negedge clk);
    force_val = v.force_val;
    force_req = 1;
    @(negedge clk);
    force_req = 0;
    repeat (v.idle_wait) @(negedge clk);
    inj_err_lo = v.err_lo;
    inj_err_hi = v.err_hi;
    req_valid  = 1'b1;
    @(posedge clk);
    wait_valid(1'b1, cyc, ok);
    check($sformatf("vec%0d_latency", idx), 64'(cyc), 64'd7);
    check($sformatf("vec%0d_data", idx), tstamp_data, v.exp_data);
    check($sformatf("vec%0d_err", idx), 64'(tstamp_err), 64'(v.exp_err));
    @(negedge clk);
    inj_err_lo = 0;
    inj_err_hi = 0;
  endtask

  initial begin
    int          cyc;
    bit          ok;
    int          viol;
    logic [63:0] prev, data0;

    // lo is read two cycles after the request edge: exp = force + idle_wait + 2.
    vecs[0] = '{64'h0,                     0, 0, 0, 64'h2,                     0};
    vecs[1] = '{64'h0000_0000_FFFF_FFFC,   4, 0, 0, 64'h0000_0001_0000_0002,   0};
    vecs[2] = '{64'h0000_0000_FFFF_FFFC,   0, 0, 0, 64'h0000_0000_FFFF_FFFE,   0};
    vecs[3] = '{64'h1234_5678_FFFF_FFFF,   1, 0, 0, 64'h1234_5679_0000_0002,   0};
    vecs[4] = '{64'h100,                   2, 0, 1, 64'h104,                   1};
    vecs[5] = '{64'h200,                   0, 1, 0, 64'h202,                   1};
    vecs[6] = '{64'h300,                   3, 0, 0, 64'h305,                   0};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_ctl", {59'd0, tstamp_valid, tstamp_err, arvalid, rready, |araddr}, 64'd0);
    check("rst_data", tstamp_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

`ifdef BSC_OMPSS_TSTAMP_PERIODIC_EN
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      wait_valid(1'b0, cyc, ok);
      check($sformatf("per%0d_timeout", i), 64'(ok), 64'd1);
      check($sformatf("per%0d_data", i), tstamp_data, last_exp_data);
      if (i > 0) check($sformatf("per%0d_delta", i), tstamp_data - prev, 64'd16);
      prev = tstamp_data;
      @(negedge clk);
    end
`else
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back requests with ready held high.
    req_valid = 1'b1;
    prev = '0;
    for (int i = 0; i < 100; i++) begin
      wait_valid(1'b0, cyc, ok);
      if (!ok) begin
        check("mono_timeout", 64'(ok), 64'd1);
        break;
      end
      check($sformatf("mono%0d_err", i), 64'(tstamp_err), 64'd0);
      check($sformatf("mono%0d_sb", i), tstamp_data, last_exp_data);
      if (i > 0) check($sformatf("mono%0d_delta", i), tstamp_data - prev, 64'd8);
      prev = tstamp_data;
      if (i == 99) req_valid = 1'b0;
      @(negedge clk);
    end

    // Backpressure: 50 stalled cycles in OUT.
    tstamp_ready = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    wait_valid(1'b1, cyc, ok);
    check("bp_timeout", 64'(ok), 64'd1);
    data0 = tstamp_data;
    viol  = 0;
    repeat (50) begin
      @(negedge clk);
      if (!tstamp_valid || tstamp_data != data0 || arvalid) viol++;
    end
    check("bp_stable", 64'(viol), 64'd0);
    tstamp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(tstamp_valid), 64'd0);

    // Reset while waiting for the low beat.
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_in_r_lo", 64'(rready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctl", {58'd0, req_ready, tstamp_valid, tstamp_err, arvalid, rready, |araddr}, 64'd0);
    check("midrst_data", tstamp_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    run_vec(vecs[6], 7);

    // Random slave latency, error injection and output backpressure.
    for (int i = 0; i < 40; i++) begin
      ar_dly       = $urandom_range(0, 3);
      r_dly        = $urandom_range(0, 3);
      inj_err_lo   = ($urandom_range(0, 3) == 0);
      inj_err_hi   = ($urandom_range(0, 3) == 0);
      tstamp_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk);
      wait_valid(1'b1, cyc, ok);
      check($sformatf("rnd%0d_timeout", i), 64'(ok), 64'd1);
      if (!ok) break;
      check($sformatf("rnd%0d_data", i), tstamp_data, last_exp_data);
      check($sformatf("rnd%0d_err", i), 64'(tstamp_err), 64'(inj_err_lo || inj_err_hi));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tstamp_ready = 1'b1;
      @(negedge clk);
    end
    tstamp_ready = 1'b1;
    inj_err_lo = 0;
    inj_err_hi = 0;
`endif

    repeat (2) @(negedge clk);
    check("protocol", 64'(prot_viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsc_ompss_tstamp_reader.md
# bsc_ompss_tstamp_reader

AXI4-Lite read master that samples the 64-bit free-running hardware counter and delivers coherent timestamps on a valid/ready stream. It sits directly downstream of the hardware counter slave, on the same clock. It reads the low word first, because that read latches the counter's upper half, then the high word, and assembles `{hi, lo}`. It serves accelerator-side instrumentation that needs timestamps without CPU involvement.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 3: AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `C_COUNTER_BASE`, 0: counter base address. Low word at base+0, high word at base+4.
- `C_PERIOD`, 1024: auto-sample period in cycles, range 2..65535. Used only with the macro described in Configuration.

Ports:
- `m_axi_aclk` in 1: single clock.
- `m_axi_areset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request one timestamp.
- `req_ready` out 1: high only in `IDLE`.
- `tstamp_data` out 64: assembled timestamp `{hi, lo}`.
- `tstamp_err` out 1: a non-OKAY `RRESP` was seen on either beat.
- `tstamp_valid` out 1: result valid.
- `tstamp_ready` in 1: result consumed.
- `m_axi_araddr` out `C_M_AXI_ADDR_WIDTH`: read address.
- `m_axi_arvalid` out 1: read address valid.
- `m_axi_arready` in 1: read address ready.
- `m_axi_rdata` in 32: read data.
- `m_axi_rresp` in 2: read response.
- `m_axi_rvalid` in 1: read data valid.
- `m_axi_rready` out 1: read data ready.

## Operation
States and transitions:
- `IDLE`: `req_ready`=1. A `req_valid` handshake moves to `AR_LO`.
- `AR_LO`: `arvalid`=1, `araddr`=base+0. Held until `arready`, then moves to `R_LO`.
- `R_LO`: `rready`=1. On `rvalid`, capture `lo` and OR `rresp!=0` into the error flag, then move to `AR_HI`.
- `AR_HI`: `arvalid`=1, `araddr`=base+4. Held until `arready`, then moves to `R_HI`.
- `R_HI`: `rready`=1. On `rvalid`, capture `hi` and OR in the error flag, then move to `OUT`.
- `OUT`: `tstamp_valid`=1, with data and error held stable. A `tstamp_ready` handshake clears the error flag and moves to `IDLE`.

Rules:
- At most one AXI transaction is outstanding.
- `araddr` is stable while `arvalid` is high.
- `arvalid` is never withdrawn before its handshake.
- An error does not abort the sequence: both reads always complete and `tstamp_data` is still presented.
- Low-then-high ordering is mandatory. The result must never be formed from a high read taken before its low read.
- No arithmetic is performed on the data; `tstamp_data` = `{hi, lo}`.

## Timing
Reset values: `req_ready`=0 while reset is asserted, and 1 after release. All other outputs are 0, and the state is `IDLE`.

Latency against a zero-wait slave (`arready` one cycle after `arvalid`, `rvalid` one cycle after the AR handshake), with the request handshake at edge T:
- `arvalid` (low word) from T+1.
- AR handshake at T+2.
- R handshake at T+3.
- `arvalid` (high word) from T+4.
- `tstamp_valid` from T+7.
- Back-to-back requests run 8 cycles apart when `tstamp_ready` is held high.

Backpressure and reset:
- Backpressure on `tstamp_ready` stalls in `OUT` indefinitely. No new AXI traffic is issued while stalled.
- Reset asserted mid-transaction abandons the sequence and returns to `IDLE` immediately. The slave has no reset, so system-level reset must cover both blocks.

## Configuration
Macro: `BSC_OMPSS_TSTAMP_PERIODIC_EN`.
- Defined: an internal 16-bit down-counter reloads with `C_PERIOD-1` and decrements every cycle. At zero it sets a pending flag. The pending flag starts a sequence from `IDLE` exactly like `req_valid`. `req_valid` still works, and starting a sequence from either source clears the pending flag. At most one pending tick is remembered; further ticks while busy are dropped.
- Undefined: samples are taken only on `req_valid`, and no period counter is synthesized.

## Structure
Package `bsc_ompss_tstamp_pkg` holds:
- The state enum (`IDLE`, `AR_LO`, `R_LO`, `AR_HI`, `R_HI`, `OUT`).
- `LO_OFFSET`=0 and `HI_OFFSET`=4.
- `RESP_OKAY`=2'b00.

Sub-module `bsc_ompss_tstamp_period` contains the period counter and pending flag, and is instantiated only under the macro.

## Test plan
- **Basic read:** hwcounter slave instantiated, reset released, one request with ready held high → `tstamp_valid` at T+7. `hi`=0, and `lo` equals the slave counter value latched at the first R-beat source cycle.
- **Monotonic:** 100 back-to-back requests → strictly increasing `tstamp_data`, delta exactly 8 each, `tstamp_err`=0 throughout.
- **High-word coherence:** slave counter forced to 0x0000_0000_FFFF_FFFC before the request → result 0x0000_0001_0000_000x, never 0x0000_0000_0000_000x.
- **Backpressure:** `tstamp_ready`=0 for 50 cycles → `tstamp_valid` and data stable, `arvalid`=0 throughout, completion on release.
- **Error response:** stub slave returns `RRESP`=2'b10 on the high beat → `tstamp_err`=1 with data still presented, and the next sample has `tstamp_err`=0.
- **Reset and periodic:** reset asserted in `R_LO` → all outputs 0 next cycle, and a clean sample after release. With the macro defined and `C_PERIOD`=16 → one timestamp every 16 cycles, delta 16.
